// File: rtl/control_pipe_pkg.sv
// Shared encodings for the P6 pipelined control unit: instruction fields,
// control codes, forwarding selects and the pipeline bubble.
package control_pipe_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a, OP_SLTIU= 6'h0b, OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d, OP_XORI = 6'h0e, OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU  = 6'h25, OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29, OP_SW   = 6'h2b;

    // R-type function codes
    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08, F_JALR = 6'h09, F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU= 6'h19, F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU = 6'h1b, F_ADD  = 6'h20, F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22, F_SUBU = 6'h23, F_AND   = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a, F_SLTU = 6'h2b;

    // Immediate extension
    localparam logic [2:0] EXT_SIGN = 3'd0, EXT_ZERO = 3'd1, EXT_LOWZERO = 3'd2;

    // Next-PC class
    localparam logic [3:0] BR_NORMAL = 4'd0, BR_BEQ = 4'd1, BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BLEZ   = 4'd3, BR_BGTZ = 4'd4, BR_J   = 4'd5;
    localparam logic [3:0] BR_JR     = 4'd6, BR_JAL  = 4'd7, BR_JALR = 4'd8;

    // Destination select
    localparam logic [1:0] RD_RD = 2'd0, RD_RT = 2'd1, RD_R31 = 2'd2;

    // Result source
    localparam logic [1:0] RES_ALU = 2'd0, RES_DM = 2'd1, RES_PC = 2'd2, RES_NW = 2'd3;

    // Forwarding selects
    localparam logic [1:0] FWD_GRF = 2'd0, FWD_E = 2'd1, FWD_M = 2'd2, FWD_W = 2'd3;

    // Operand not read: larger than any Tnew, so it never stalls
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Pipeline bubble
    localparam logic [4:0] BUBBLE_A3  = 5'd0;
    localparam logic [1:0] BUBBLE_RES = RES_NW;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_op_e;

    // Cycles until the result exists, counted from entry to E
    function automatic logic [1:0] tnew_of(input logic [1:0] res);
        case (res)
            RES_ALU: return 2'd1;
            RES_DM:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/control_pipe_if.sv
// Instruction in and all control/hazard outputs of the pipelined control unit.
interface control_pipe_if;
    import control_pipe_pkg::*;

    logic [31:0] IR_D;
    logic [2:0]  Extop_D;
    logic [3:0]  Branch_D;
    logic [1:0]  regdst_D;
    logic        stall;
    logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;
    logic [1:0]  Res_E, Res_M, Res_W;
    logic [4:0]  A3_E, A3_M, A3_W;
    logic        md_busy;

    modport master (
        output IR_D,
        input  Extop_D, Branch_D, regdst_D, stall,
        input  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M,
        input  Res_E, Res_M, Res_W, A3_E, A3_M, A3_W, md_busy
    );

    modport slave (
        input  IR_D,
        output Extop_D, Branch_D, regdst_D, stall,
        output fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M,
        output Res_E, Res_M, Res_W, A3_E, A3_M, A3_W, md_busy
    );
endinterface

// File: rtl/control_pipe_decode_fields.sv
// Combinational instruction decode into control fields, hazard timing and
// mult/div usage for one pipeline stage.
module decode_fields
    import control_pipe_pkg::*;
(
    input  logic [31:0] ir,
    output logic [2:0]  extop,
    output logic [3:0]  branch,
    output logic [1:0]  regdst,
    output logic [1:0]  res,
    output logic [4:0]  a3,
    output logic [1:0]  tuse_rs,
    output logic [1:0]  tuse_rt,
    output logic [1:0]  tnew0,
    output md_op_e      md_start,
    output logic        md_use
);

    logic [5:0] op, funct;
    logic       unused_ir;

    assign op        = ir[31:26];
    assign funct     = ir[5:0];
    assign unused_ir = ^{ir[25:21], ir[10:6]};

    // Field decode; a3 and tnew0 follow from regdst and res
    always_comb begin
        extop    = EXT_SIGN;
        branch   = BR_NORMAL;
        regdst   = RD_RD;
        res      = RES_NW;
        tuse_rs  = TUSE_NONE;
        tuse_rt  = TUSE_NONE;
        md_start = MD_NONE;
        md_use   = 1'b0;
        a3       = 5'd0;
        tnew0    = 2'd0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU, F_SLLV, F_SRLV, F_SRAV: begin
                        res = RES_ALU; tuse_rs = 2'd1; tuse_rt = 2'd1;
                    end
                    F_SLL, F_SRL, F_SRA: begin
                        res = RES_ALU; tuse_rt = 2'd1;
                    end
                    F_JR:   begin branch = BR_JR; tuse_rs = 2'd0; end
                    F_JALR: begin branch = BR_JALR; res = RES_PC; tuse_rs = 2'd0; end
                    F_MFHI, F_MFLO: begin res = RES_ALU; md_use = 1'b1; end
                    F_MTHI, F_MTLO: begin tuse_rs = 2'd1; md_use = 1'b1; end
                    F_MULT, F_MULTU: begin
                        tuse_rs = 2'd1; tuse_rt = 2'd1; md_use = 1'b1; md_start = MD_MULT;
                    end
                    F_DIV, F_DIVU: begin
                        tuse_rs = 2'd1; tuse_rt = 2'd1; md_use = 1'b1; md_start = MD_DIV;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                regdst = RD_RT; res = RES_ALU; tuse_rs = 2'd1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                extop = EXT_ZERO; regdst = RD_RT; res = RES_ALU; tuse_rs = 2'd1;
            end
            OP_LUI: begin extop = EXT_LOWZERO; regdst = RD_RT; res = RES_ALU; end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                regdst = RD_RT; res = RES_DM; tuse_rs = 2'd1;
            end
            OP_SB, OP_SH, OP_SW: begin tuse_rs = 2'd1; tuse_rt = 2'd2; end
            OP_BEQ:  begin branch = BR_BEQ;  tuse_rs = 2'd0; tuse_rt = 2'd0; end
            OP_BNE:  begin branch = BR_BNE;  tuse_rs = 2'd0; tuse_rt = 2'd0; end
            OP_BLEZ: begin branch = BR_BLEZ; tuse_rs = 2'd0; end
            OP_BGTZ: begin branch = BR_BGTZ; tuse_rs = 2'd0; end
            OP_J:    branch = BR_J;
            OP_JAL:  begin branch = BR_JAL; regdst = RD_R31; res = RES_PC; end
            default: ;
        endcase
        if (res != RES_NW) begin
            case (regdst)
                RD_RT:   a3 = ir[20:16];
                RD_R31:  a3 = 5'd31;
                default: a3 = ir[15:11];
            endcase
        end
        tnew0 = tnew_of(res);
    end

endmodule

// File: rtl/control_pipe.sv
// P6 pipelined control: D decode, E/M/W destination bundles, stall and
// forwarding selects, and the mult/div busy counter.
module control_pipe
    import control_pipe_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int TNEW_W   = 2
) (
    input logic           clk,
    input logic           reset,
    control_pipe_if.slave bus
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    logic [4:0]  rs_d, rt_d, a3_d;
    logic [1:0]  res_d, tuse_rs_d, tuse_rt_d, tnew0_d;
    md_op_e      md_start_d;
    logic        md_use_d;

    logic [4:0]        a3_p0, rs_p0, rt_p0, a3_p1, rt_p1, a3_p2;
    logic [1:0]        res_p0, res_p1, res_p2;
    logic [TNEW_W-1:0] tnew_p0, tnew_p1, tnew_p2;
    md_op_e            md_p0;
    logic [CNT_W-1:0]  cnt;

    logic stall_rs, stall_rt, md_busy, stall;

    function automatic logic [TNEW_W-1:0] tnew_dec_sat(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    function automatic logic stall_hit(input logic [4:0] addr, input logic [1:0] tuse,
                                       input logic [4:0] a3, input logic [TNEW_W-1:0] tnew);
        return (addr != 5'd0) && (a3 == addr) && (int'(tuse) < int'(tnew));
    endfunction

    function automatic logic fwd_hit(input logic [4:0] addr, input logic [4:0] a3,
                                     input logic [TNEW_W-1:0] tnew);
        return (addr != 5'd0) && (a3 == addr) && (tnew == '0);
    endfunction

    assign rs_d = bus.IR_D[25:21];
    assign rt_d = bus.IR_D[20:16];

    decode_fields u_dec (
        .ir       (bus.IR_D),
        .extop    (bus.Extop_D),
        .branch   (bus.Branch_D),
        .regdst   (bus.regdst_D),
        .res      (res_d),
        .a3       (a3_d),
        .tuse_rs  (tuse_rs_d),
        .tuse_rt  (tuse_rt_d),
        .tnew0    (tnew0_d),
        .md_start (md_start_d),
        .md_use   (md_use_d)
    );

    // Hazard detection against producers still in flight in E and M
    assign stall_rs = stall_hit(rs_d, tuse_rs_d, a3_p0, tnew_p0)
                    | stall_hit(rs_d, tuse_rs_d, a3_p1, tnew_p1);
    assign stall_rt = stall_hit(rt_d, tuse_rt_d, a3_p0, tnew_p0)
                    | stall_hit(rt_d, tuse_rt_d, a3_p1, tnew_p1);
    assign md_busy  = (md_p0 != MD_NONE) || (cnt != '0);
    assign stall    = stall_rs | stall_rt | (md_use_d & md_busy);

    // Forwarding: nearest ready producer wins; W reaches D through the register file
    assign bus.fwd_rs_D = fwd_hit(rs_d, a3_p0, tnew_p0) ? FWD_E :
                          fwd_hit(rs_d, a3_p1, tnew_p1) ? FWD_M : FWD_GRF;
    assign bus.fwd_rt_D = fwd_hit(rt_d, a3_p0, tnew_p0) ? FWD_E :
                          fwd_hit(rt_d, a3_p1, tnew_p1) ? FWD_M : FWD_GRF;
    assign bus.fwd_rs_E = fwd_hit(rs_p0, a3_p1, tnew_p1) ? FWD_M :
                          fwd_hit(rs_p0, a3_p2, tnew_p2) ? FWD_W : FWD_GRF;
    assign bus.fwd_rt_E = fwd_hit(rt_p0, a3_p1, tnew_p1) ? FWD_M :
                          fwd_hit(rt_p0, a3_p2, tnew_p2) ? FWD_W : FWD_GRF;
    assign bus.fwd_rt_M = fwd_hit(rt_p1, a3_p2, tnew_p2) ? FWD_W : FWD_GRF;

    assign bus.stall   = stall;
    assign bus.md_busy = md_busy;
    assign bus.A3_E    = a3_p0;
    assign bus.A3_M    = a3_p1;
    assign bus.A3_W    = a3_p2;
    assign bus.Res_E   = res_p0;
    assign bus.Res_M   = res_p1;
    assign bus.Res_W   = res_p2;

    // Stage registers: E takes D or a bubble on stall; M and W always advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a3_p0 <= BUBBLE_A3; res_p0 <= BUBBLE_RES; tnew_p0 <= '0;
            rs_p0 <= 5'd0; rt_p0 <= 5'd0; md_p0 <= MD_NONE;
            a3_p1 <= BUBBLE_A3; res_p1 <= BUBBLE_RES; tnew_p1 <= '0; rt_p1 <= 5'd0;
            a3_p2 <= BUBBLE_A3; res_p2 <= BUBBLE_RES; tnew_p2 <= '0;
        end else begin
            // D -> E
            if (stall) begin
                a3_p0 <= BUBBLE_A3; res_p0 <= BUBBLE_RES; tnew_p0 <= '0;
                rs_p0 <= 5'd0; rt_p0 <= 5'd0; md_p0 <= MD_NONE;
            end else begin
                a3_p0 <= a3_d; res_p0 <= res_d; tnew_p0 <= TNEW_W'(tnew0_d);
                rs_p0 <= rs_d; rt_p0 <= rt_d; md_p0 <= md_start_d;
            end
            // E -> M
            a3_p1 <= a3_p0; res_p1 <= res_p0; tnew_p1 <= tnew_dec_sat(tnew_p0);
            rt_p1 <= rt_p0;
            // M -> W
            a3_p2 <= a3_p1; res_p2 <= res_p1; tnew_p2 <= tnew_dec_sat(tnew_p1);
        end
    end

    // Busy counter: an E-stage start always advances, so it always arms the unit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (md_p0 == MD_DIV) begin
            cnt <= CNT_W'(DIV_LAT - 1);
        end else if (md_p0 == MD_MULT) begin
            cnt <= CNT_W'(MULT_LAT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule
